// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM sharing one edge/center period counter, with shadowed duty/period/mode updates.
// Latency: pwm is registered one cycle after cntr. Shadow regs load on period_end, or every cycle while en=0.
// Backpressure: none, write strobes are always accepted. PWM_POLARITY_INV_EN adds the pol_inv input for per-channel inversion.
module pwm_multi_channel #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      align_center,
    input  logic [WIDTH-1:0]          period,
    input  logic                      period_wr,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       duty_wr,
`ifdef PWM_POLARITY_INV_EN
    input  logic [CHANNELS-1:0]       pol_inv,
`endif
    output logic [CHANNELS-1:0]       pwm,
    output logic [WIDTH-1:0]          cntr,
    output logic                      period_end
);

    logic                           dir;   // 1 = counting down (center mode only)
    logic                           armed;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_pend, duty_act, duty_eff, duty_nxt;
    logic [WIDTH-1:0]               period_pend, period_act, period_eff, period_nxt;
    logic                           mode_pend, mode_act, mode_eff, mode_nxt;
    logic [CHANNELS-1:0]            pol_act;
    logic                           at_end, load;
    logic [WIDTH-1:0]               cntr_nxt;
    logic                           dir_nxt;
    logic [CHANNELS-1:0]            pwm_nxt;

    // A write landing on the load cycle bypasses pending, so no period is lost.
    always_comb begin
        duty_eff = duty_pend;
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr[i]) begin
                duty_eff[i] = duty[i*WIDTH +: WIDTH];
            end
        end
        period_eff = period_wr ? period : period_pend;
        mode_eff   = period_wr ? align_center : mode_pend;
        load       = ~en | period_end;
        duty_nxt   = load ? duty_eff   : duty_act;
        period_nxt = load ? period_eff : period_act;
        mode_nxt   = load ? mode_eff   : mode_act;
    end

`ifdef PWM_POLARITY_INV_EN
    logic [CHANNELS-1:0] pol_pend, pol_eff;

    always_comb begin
        pol_eff = pol_pend;
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr[i]) begin
                pol_eff[i] = pol_inv[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pol_pend <= '0;
            pol_act  <= '0;
        end else begin
            pol_pend <= pol_eff;
            if (load) begin
                pol_act <= pol_eff;
            end
        end
    end
`else
    assign pol_act = '0;
`endif

    // Edge ends at the top of the sawtooth; center ends at the valley on the way down.
    assign at_end = (period_act == '0)
                  | (~mode_act & (cntr == period_act))
                  | (mode_act & dir & (cntr == '0));

    // armed masks the cycle right after reset release, keeping period_end low during reset.
    assign period_end = en & armed & at_end;

    always_comb begin
        cntr_nxt = cntr;
        dir_nxt  = dir;
        if (!en) begin
            cntr_nxt = '0;
            dir_nxt  = 1'b0;
        end else if (at_end) begin
            dir_nxt = 1'b0;
            // Steady center mode skips the repeated valley; a mode change restarts from 0.
            if ((mode_nxt == mode_act) && mode_nxt && (period_nxt != '0)) begin
                cntr_nxt = WIDTH'(1);
            end else begin
                cntr_nxt = '0;
            end
        end else if (!mode_act) begin
            cntr_nxt = cntr + WIDTH'(1);
        end else if (!dir) begin
            if (cntr == period_act) begin
                cntr_nxt = cntr - WIDTH'(1);
                dir_nxt  = 1'b1;
            end else begin
                cntr_nxt = cntr + WIDTH'(1);
            end
        end else begin
            cntr_nxt = cntr - WIDTH'(1);
        end
    end

    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_nxt[i] = en & ((cntr < duty_act[i]) ^ pol_act[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntr        <= '0;
            dir         <= 1'b0;
            armed       <= 1'b0;
            pwm         <= '0;
            duty_pend   <= '0;
            duty_act    <= '0;
            period_pend <= '0;
            period_act  <= '0;
            mode_pend   <= 1'b0;
            mode_act    <= 1'b0;
        end else begin
            cntr        <= cntr_nxt;
            dir         <= dir_nxt;
            armed       <= 1'b1;
            pwm         <= pwm_nxt;
            duty_pend   <= duty_eff;
            duty_act    <= duty_nxt;
            period_pend <= period_eff;
            period_act  <= period_nxt;
            mode_pend   <= mode_eff;
            mode_act    <= mode_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: reset, edge, center, shadowing, en=0 load, zero period.
module tb_pwm_multi_channel;
    localparam int WIDTH    = 10;
    localparam int CHANNELS = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      en;
    logic                      align_center;
    logic [WIDTH-1:0]          period;
    logic                      period_wr;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS-1:0]       duty_wr;
    logic [CHANNELS-1:0]       pwm;
    logic [WIDTH-1:0]          cntr;
    logic                      period_end;
`ifdef PWM_POLARITY_INV_EN
    logic [CHANNELS-1:0]       pol_inv;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int center_seq [17] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0};

    pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .align_center (align_center),
        .period       (period),
        .period_wr    (period_wr),
        .duty         (duty),
        .duty_wr      (duty_wr),
`ifdef PWM_POLARITY_INV_EN
        .pol_inv      (pol_inv),
`endif
        .pwm          (pwm),
        .cntr         (cntr),
        .period_end   (period_end)
    );

    always #5 clk = ~clk;

    task automatic cfg(input logic [WIDTH-1:0] p, input logic m,
                       input logic [CHANNELS*WIDTH-1:0] d, input logic [CHANNELS-1:0] mask);
        @(negedge clk);
        period = p; align_center = m; period_wr = 1'b1; duty = d; duty_wr = mask;
        @(negedge clk);
        period_wr = 1'b0; duty_wr = '0;
    endtask

    task automatic test_reset();
        #2;
        n_checks += 3;
        if (cntr !== 10'd0) begin n_fail++; $display("FAIL reset_cntr got=%0d exp=0", cntr); end
        if (pwm !== 4'b0000) begin n_fail++; $display("FAIL reset_pwm got=%b exp=0000", pwm); end
        if (period_end !== 1'b0) begin n_fail++; $display("FAIL reset_period_end got=%b exp=0", period_end); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_edge();
        logic [WIDTH-1:0] ec;
        logic [3:0] ep;
        @(negedge clk); en = 1'b0;
        cfg(10'd9, 1'b0, {10'd15, 10'd10, 10'd0, 10'd3}, 4'hf);
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ec = WIDTH'(k % 10);
            ep = {3'b110, 1'(((k - 1) % 10) < 3)};
            n_checks += 3;
            if (cntr !== ec) begin n_fail++; $display("FAIL edge_cntr k=%0d got=%0d exp=%0d", k, cntr, ec); end
            if (period_end !== 1'(k % 10 == 9)) begin n_fail++; $display("FAIL edge_period_end k=%0d got=%b exp=%b", k, period_end, k % 10 == 9); end
            if (pwm !== ep) begin n_fail++; $display("FAIL edge_pwm k=%0d got=%b exp=%b", k, pwm, ep); end
        end
    endtask

    task automatic test_center();
        logic [WIDTH-1:0] ec;
        logic [3:0] ep;
        int highs;
        highs = 0;
        @(negedge clk); en = 1'b0;
        cfg(10'd4, 1'b1, {10'd0, 10'd0, 10'd0, 10'd2}, 4'h1);
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            ec = WIDTH'(center_seq[k]);
            ep = {3'b110, 1'(center_seq[k-1] < 2)};
            if (k > 8 && pwm[0]) highs++;
            n_checks += 3;
            if (cntr !== ec) begin n_fail++; $display("FAIL center_cntr k=%0d got=%0d exp=%0d", k, cntr, ec); end
            if (period_end !== 1'(k == 8 || k == 16)) begin n_fail++; $display("FAIL center_period_end k=%0d got=%b", k, period_end); end
            if (pwm !== ep) begin n_fail++; $display("FAIL center_pwm k=%0d got=%b exp=%b", k, pwm, ep); end
        end
        n_checks++;
        if (highs !== 3) begin n_fail++; $display("FAIL center_high_cycles got=%0d exp=3", highs); end
    endtask

    task automatic test_shadow();
        int d;
        logic [3:0] ep;
        @(negedge clk); en = 1'b0;
        cfg(10'd9, 1'b0, {10'd0, 10'd0, 10'd0, 10'd3}, 4'h1);
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            d  = (k <= 10) ? 3 : (k <= 20) ? 7 : 5;
            ep = {3'b110, 1'(((k - 1) % 10) < d)};
            n_checks += 2;
            if (pwm !== ep) begin n_fail++; $display("FAIL shadow_pwm k=%0d got=%b exp=%b", k, pwm, ep); end
            if (cntr !== WIDTH'(k % 10)) begin n_fail++; $display("FAIL shadow_cntr k=%0d got=%0d exp=%0d", k, cntr, k % 10); end
            if (k == 4) begin
                duty[9:0] = 10'd7; duty_wr = 4'h1;
            end else if (k == 19) begin
                duty[9:0] = 10'd5; duty_wr = 4'h1;
            end else begin
                duty_wr = 4'h0;
            end
        end
    endtask

    task automatic test_disabled_load();
        logic [3:0] ep;
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (pwm !== 4'b0000) begin n_fail++; $display("FAIL dis_pwm got=%b exp=0000", pwm); end
        if (period_end !== 1'b0) begin n_fail++; $display("FAIL dis_period_end got=%b exp=0", period_end); end
        if (cntr !== 10'd0) begin n_fail++; $display("FAIL dis_cntr got=%0d exp=0", cntr); end
        duty[9:0] = 10'd2; duty_wr = 4'h1;
        @(negedge clk);
        duty_wr = 4'h0; en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ep = {3'b110, 1'((k - 1) < 2)};
            n_checks++;
            if (pwm !== ep) begin n_fail++; $display("FAIL dis_load_pwm k=%0d got=%b exp=%b", k, pwm, ep); end
        end
    endtask

    task automatic test_period_zero();
        @(negedge clk); en = 1'b0;
        cfg(10'd0, 1'b0, {10'd0, 10'd0, 10'd0, 10'd3}, 4'h1);
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_checks += 3;
            if (cntr !== 10'd0) begin n_fail++; $display("FAIL p0_cntr k=%0d got=%0d exp=0", k, cntr); end
            if (period_end !== 1'b1) begin n_fail++; $display("FAIL p0_period_end k=%0d got=%b exp=1", k, period_end); end
            if (pwm !== 4'b1101) begin n_fail++; $display("FAIL p0_pwm k=%0d got=%b exp=1101", k, pwm); end
        end
        @(negedge clk); en = 1'b0;
        #1;
        n_checks++;
        if (period_end !== 1'b0) begin n_fail++; $display("FAIL p0_dis_period_end got=%b exp=0", period_end); end
        @(negedge clk);
        n_checks++;
        if (pwm !== 4'b0000) begin n_fail++; $display("FAIL p0_dis_pwm got=%b exp=0000", pwm); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); en = 1'b0;
        cfg(10'd9, 1'b0, {10'd0, 10'd0, 10'd0, 10'd3}, 4'h1);
        @(negedge clk); en = 1'b1;
        repeat (5) @(negedge clk);
        n_checks += 2;
        if (cntr !== 10'd5) begin n_fail++; $display("FAIL rmid_pre_cntr got=%0d exp=5", cntr); end
        if (pwm !== 4'b1100) begin n_fail++; $display("FAIL rmid_pre_pwm got=%b exp=1100", pwm); end
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (cntr !== 10'd0) begin n_fail++; $display("FAIL rmid_cntr got=%0d exp=0", cntr); end
        if (pwm !== 4'b0000) begin n_fail++; $display("FAIL rmid_pwm got=%b exp=0000", pwm); end
        if (period_end !== 1'b0) begin n_fail++; $display("FAIL rmid_period_end got=%b exp=0", period_end); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks += 3;
            if (cntr !== 10'd0) begin n_fail++; $display("FAIL rmid_post_cntr k=%0d got=%0d exp=0", k, cntr); end
            if (period_end !== 1'b1) begin n_fail++; $display("FAIL rmid_post_period_end k=%0d got=%b exp=1", k, period_end); end
            if (pwm !== 4'b0000) begin n_fail++; $display("FAIL rmid_post_pwm k=%0d got=%b exp=0000", k, pwm); end
        end
    endtask

`ifdef PWM_POLARITY_INV_EN
    task automatic test_polarity();
        logic [3:0] ep;
        @(negedge clk); en = 1'b0; pol_inv = 4'b0001;
        cfg(10'd9, 1'b0, {10'd15, 10'd10, 10'd0, 10'd3}, 4'hf);
        pol_inv = 4'b0000;
        @(negedge clk); en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            ep = {3'b110, 1'(((k - 1) % 10) >= 3)};
            n_checks++;
            if (pwm !== ep) begin n_fail++; $display("FAIL pol_pwm k=%0d got=%b exp=%b", k, pwm, ep); end
        end
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pwm !== 4'b0000) begin n_fail++; $display("FAIL pol_dis_pwm got=%b exp=0000", pwm); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; en = 1'b1; align_center = 1'b0; period = '0; period_wr = 1'b0;
        duty = '0; duty_wr = '0;
`ifdef PWM_POLARITY_INV_EN
        pol_inv = '0;
`endif
        test_reset();
        test_edge();
        test_center();
        test_shadow();
        test_disabled_load();
        test_period_zero();
        test_reset_mid();
`ifdef PWM_POLARITY_INV_EN
        test_polarity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
